io_port_fl: RTL
===============

Name: io_port_fl

Overview:
- Peripheral-side responder for the floating-point core's I/O interface.
- Serves the core's reads (req_in/addr_in/io_in) from per-channel input holding registers filled by external valid/ready producers.
- Captures the core's writes (out_en/addr_out/data_out) into per-channel output registers drained by external valid/ready consumers.
- The core never stalls, so loss and staleness are flagged in sticky status bits rather than back-pressured.

Parameters:
- NBMANT, 16, mantissa bits.
- NBEXPO, 6, exponent bits.
- W, NBMANT+NBEXPO+1, data word width. Derived; do not override.
- NUIOIN, 8, number of input channels.
- NUIOOU, 8, number of output channels.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_in  in  1  core read strobe; consumes the addressed input channel.
- addr_in  in  $clog2(NUIOIN)  core read address.
- io_in  out  W  data returned to the core.
- out_en  in  1  core write strobe.
- addr_out  in  $clog2(NUIOOU)  core write address.
- data_out  in  W  data written by the core.
- ext_in_data  in  NUIOIN*W  producer data, channel i at [i*W +: W].
- ext_in_valid  in  NUIOIN  producer valid.
- ext_in_ready  out  NUIOIN  block ready.
- ext_out_data  out  NUIOOU*W  consumer data, channel j at [j*W +: W].
- ext_out_valid  out  NUIOOU  block valid.
- ext_out_ready  in  NUIOOU  consumer ready.
- in_underflow  out  NUIOIN  sticky: core read an empty input channel.
- out_overflow  out  NUIOOU  sticky: core overwrote an unconsumed output word.
- clr_status  in  1  synchronous clear of both sticky vectors.

Behaviour:
- Reset (rst=0, asynchronous):
  - All holding and output registers are 0; all full/valid flags are 0; sticky vectors are 0.
  - ext_in_ready is forced to 0 while rst=0.
  - ext_out_valid=0. io_in=0 because hold[0] is 0.
  - Reset mid-transfer discards the word in flight; no partial state survives.
- Input channel i:
  - State is full_i plus hold_i.
  - ext_in_ready[i] = rst & (!full_i | (req_in & addr_in==i)).
  - On ext_in_valid[i] & ext_in_ready[i]: hold_i <= ext_in_data slice and full_i <= 1 at the edge.
- Core read:
  - io_in = hold[addr_in], combinational, zero latency, regardless of req_in.
  - If addr_in >= NUIOIN, io_in = 0.
  - req_in & addr_in==i clears full_i at the next edge, unless a producer load occurs in the same cycle. In that case full_i stays 1 and hold_i takes the new word; the core saw the old word this cycle.
  - req_in to an empty channel returns the stale hold_i and sets in_underflow[i]. hold_i is unchanged.
- Output channel j:
  - out_en & addr_out==j loads oreg_j <= data_out and sets valid_j <= 1 at the next edge.
  - If valid_j=1 and ext_out_ready[j]=0 in that cycle, the old word is lost and out_overflow[j] is set.
  - If ext_out_ready[j]=1 in the same cycle, the old word is consumed and the new word is loaded; no overflow.
  - ext_out_data slice j = oreg_j; ext_out_valid[j] = valid_j.
  - On valid_j & ext_out_ready[j] with no simultaneous write, valid_j <= 0. oreg_j holds its value.
  - If addr_out >= NUIOOU, the write is ignored.
- req_in and out_en in the same cycle are independent; both are honoured.
- clr_status clears both sticky vectors at the next edge. A set condition in the same cycle wins, so the bit stays 1.
- Latency:
  - Producer to core-visible: 1 edge.
  - Core write to ext_out_valid: 1 edge.
- Throughput: one word per channel per cycle in each direction.

Decomposition:
- Shared package io_fl_pkg holds:
  - W computation.
  - Address widths AIN=$clog2(NUIOIN) and AOUT=$clog2(NUIOOU).
  - Slice helper for flattened buses.
- Sub-module io_slot_fl: one W-bit register with full flag, load/consume inputs, and an overrun/underrun pulse output.
- io_port_fl instantiates NUIOIN + NUIOOU io_slot_fl in generate loops and adds the io_in mux and the sticky registers.

Test Plan (W=23):
1. Reset then release:
   - Stimulus: rst low, then high.
   - Response: io_in=0, ext_out_valid=0, all ext_in_ready=1, sticky=0. ext_in_ready=0 while rst low.
2. Produce and read:
   - Stimulus: ext_in_valid[3]=1 with 0x1A2B3C; next cycle req_in=1, addr_in=3.
   - Response: io_in=0x1A2B3C that cycle; full_3 clears next edge; ext_in_ready[3]=1 throughout the read cycle.
3. Underflow:
   - Stimulus: req_in=1, addr_in=5 on an empty channel.
   - Response: io_in=0; in_underflow=0x20 next cycle.
   - Stimulus: clr_status=1.
   - Response: in_underflow=0.
4. Output handshake:
   - Stimulus: out_en=1, addr_out=2, data_out=0x400000.
   - Response: next cycle ext_out_valid[2]=1 with ext_out_data slice 2 = 0x400000.
   - Stimulus: ext_out_ready[2]=1 for one cycle.
   - Response: valid drops.
5. Overflow:
   - Stimulus: two writes to channel 6 (0x000001 then 0x000002) with ext_out_ready[6]=0.
   - Response: slice 6 = 0x000002, out_overflow[6]=1.
   - Stimulus: repeat with ready=1 during the second write.
   - Response: no overflow.
6. Simultaneous events:
   - Read and producer load on channel 0 in the same cycle: full_0 stays 1 and the new word is visible next cycle.
   - Asynchronous reset asserted mid-burst: all flags clear immediately.

Source files
------------

// File: rtl/io_fl_pkg.sv
// Shared sizing and bus helpers for the floating-point core I/O port.
// Default geometry lives here so the port and its bench agree on word layout.
package io_fl_pkg;

  localparam int DEF_NBMANT = 16;
  localparam int DEF_NBEXPO = 6;
  localparam int DEF_NUIOIN = 8;
  localparam int DEF_NUIOOU = 8;

  // Sign + exponent + mantissa.
  function automatic int word_w(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction

  localparam int W    = word_w(DEF_NBMANT, DEF_NBEXPO);
  localparam int AIN  = $clog2(DEF_NUIOIN);
  localparam int AOUT = $clog2(DEF_NUIOOU);
  localparam int BUS_W = ((DEF_NUIOIN > DEF_NUIOOU) ? DEF_NUIOIN : DEF_NUIOOU) * W;

  // Word idx of a flattened channel bus laid out as channel k at [k*W +: W].
  function automatic logic [W-1:0] bus_slice(input logic [BUS_W-1:0] bus, input int idx);
    return bus[idx*W +: W];
  endfunction

endpackage

// File: rtl/io_slot_fl.sv
// One word register with a full flag; err pulses on a consume of an empty slot
// or a load that overwrites an unconsumed word.
module io_slot_fl
  import io_fl_pkg::*;
#(
  parameter int DW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          consume,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          err
);

  // NOTE: the data word is reset too, because a read of a never-filled slot must return 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking so every slot samples the same pre-edge state.
      dout <= din;
      full <= 1'b1;
    end else if (consume) begin
      full <= 1'b0;
    end
  end

  // A load concurrent with a consume replaces the word cleanly.
  assign err = (consume && !full) || (load && full && !consume);

endmodule

// File: rtl/io_port_fl.sv
// Peripheral responder for the FP core: input holding slots feed core reads,
// output slots capture core writes; loss and staleness go to sticky status bits.
module io_port_fl
  import io_fl_pkg::*;
#(
  parameter  int NBMANT = DEF_NBMANT,
  parameter  int NBEXPO = DEF_NBEXPO,
  parameter  int NUIOIN = DEF_NUIOIN,
  parameter  int NUIOOU = DEF_NUIOOU,
  localparam int W      = word_w(NBMANT, NBEXPO)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic [$clog2(NUIOIN)-1:0] addr_in,
  output logic [W-1:0]              io_in,
  input  logic                      out_en,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic [W-1:0]              data_out,
  input  logic [NUIOIN*W-1:0]       ext_in_data,
  input  logic [NUIOIN-1:0]         ext_in_valid,
  output logic [NUIOIN-1:0]         ext_in_ready,
  output logic [NUIOOU*W-1:0]       ext_out_data,
  output logic [NUIOOU-1:0]         ext_out_valid,
  input  logic [NUIOOU-1:0]         ext_out_ready,
  output logic [NUIOIN-1:0]         in_underflow,
  output logic [NUIOOU-1:0]         out_overflow,
  input  logic                      clr_status
);

  logic [W-1:0]      hold [NUIOIN];
  logic [NUIOIN-1:0] in_full, in_load, in_consume, in_err;
  logic [NUIOOU-1:0] out_write, out_take, out_err;

  for (genvar i = 0; i < NUIOIN; i++) begin : g_in
    assign in_consume[i]   = req_in && (int'(addr_in) == i);
    // A full slot still accepts a word in the cycle the core drains it.
    assign ext_in_ready[i] = rst && (!in_full[i] || in_consume[i]);
    assign in_load[i]      = ext_in_valid[i] && ext_in_ready[i];

    io_slot_fl #(.DW(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (in_load[i]),
      .din     (ext_in_data[i*W +: W]),
      .consume (in_consume[i]),
      .dout    (hold[i]),
      .full    (in_full[i]),
      .err     (in_err[i])
    );
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    assign out_write[j] = out_en && (int'(addr_out) == j);
    assign out_take[j]  = ext_out_valid[j] && ext_out_ready[j];

    io_slot_fl #(.DW(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (out_write[j]),
      .din     (data_out),
      .consume (out_take[j]),
      .dout    (ext_out_data[j*W +: W]),
      .full    (ext_out_valid[j]),
      .err     (out_err[j])
    );
  end

  // NOTE: default first so every path assigns io_in and no latch is inferred.
  always_comb begin
    io_in = '0;
    if (int'(addr_in) < NUIOIN) io_in = hold[addr_in];
  end

  // A set condition in the clear cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_underflow <= '0;
      out_overflow <= '0;
    end else begin
      in_underflow <= (clr_status ? '0 : in_underflow) | in_err;
      out_overflow <= (clr_status ? '0 : out_overflow) | out_err;
    end
  end

endmodule
